// File: rtl/bus_slave_ram.sv
// bus_slave_ram: jpu bus responder backed by a synchronous RAM, with optional
// wait states, out-of-range errors and (BUS_SLAVE_KPROT_EN) kernel protection.
//
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   bus_i  in  bus::m2s_s request (req, we, addr, data, byte_mask, user_mode)
//   bus_o  out bus::s2m_s response (valid, stall, err, data)
//
// Build option: define BUS_SLAVE_KPROT_EN to reject user-mode accesses to
// the lowest KPROT_WORDS words of the range.

package bus;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  byte_mask;
      logic        user_mode;
   } m2s_s;

   typedef struct packed {
      logic        valid;
      logic        stall;
      logic        err;
      logic [31:0] data;
   } s2m_s;
endpackage

module bus_slave_ram #(
   parameter int          ADDR_W      = 10,
   parameter logic [29:0] BASE_ADDR   = 30'h0,
   parameter int          WAIT_CYCLES = 0,
   parameter int          KPROT_WORDS = 256,
   parameter              INIT_FILE   = ""
) (
   input  logic      clk,
   input  logic      rst,
   input  bus::m2s_s bus_i,
   output bus::s2m_s bus_o
);

   localparam logic [3:0] N        = 4'(WAIT_CYCLES);
   localparam logic       USE_WAIT = (WAIT_CYCLES > 0);
   localparam logic       USER     = 1'b1;
   localparam int         DEPTH    = 2 ** ADDR_W;

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   bus::m2s_s   hold_q;
   logic        valid_q;
   logic        err_q;
   logic [31:0] data_q;
   logic [31:0] mem_q [DEPTH];

   logic        accept;
   logic        stall_c;
   logic        strobe_c;
   bus::m2s_s   src;
   logic        hit;
   logic        kerr;
   logic        acc_err;
   logic [ADDR_W-1:0] off;
   logic        unused_ok;

   assign accept = (state_q == S_IDLE) && bus_i.req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && USE_WAIT) begin
               state_d = S_WAIT;
               cnt_d   = N - 4'd1;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // With no wait states the RAM is strobed straight from the bus in the
   // accept cycle; otherwise from the hold register at the end of WAIT.
   always_comb begin
      stall_c  = 1'b0;
      strobe_c = 1'b0;
      src      = bus_i;
      unique case (state_q)
         S_IDLE: begin
            stall_c  = bus_i.req && USE_WAIT;
            strobe_c = accept && !USE_WAIT;
         end
         S_WAIT: begin
            stall_c  = (cnt_q != 4'd0);
            strobe_c = (cnt_q == 4'd0);
         end
         default: ;
      endcase
      if (USE_WAIT) src = hold_q;
   end

   always_ff @(posedge clk) begin
      if (accept) hold_q <= bus_i;
   end

   assign hit = (src.addr[29:ADDR_W] == BASE_ADDR[29:ADDR_W]);
   assign off = src.addr[ADDR_W-1:0];

`ifdef BUS_SLAVE_KPROT_EN
   assign kerr = (src.user_mode == USER) && (32'(off) < KPROT_WORDS);
`else
   assign kerr = 1'b0;
`endif

   assign acc_err   = !hit || kerr;
   assign unused_ok = ^{src.req, src.user_mode, USER};

   // Not gated by rst: a write strobed in the reset cycle still lands.
   always_ff @(posedge clk) begin
      if (strobe_c && src.we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (src.byte_mask[i])
               mem_q[off][8*i +: 8] <= src.data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= 32'd0;
      end else begin
         valid_q <= strobe_c;
         err_q   <= strobe_c && acc_err;
         if (strobe_c && !acc_err && !src.we) data_q <= mem_q[off];
         else                                 data_q <= 32'd0;
      end
   end

   always_comb begin
      bus_o       = '0;
      bus_o.valid = valid_q;
      bus_o.stall = stall_c;
      bus_o.err   = err_q;
      bus_o.data  = data_q;
   end

endmodule

// File: tb/tb_bus_slave_ram.sv
// tb_bus_slave_ram: scoreboard bench for bus_slave_ram at 0, 3 and 4 wait
// states, with a word/byte-level memory model and per-cycle stall checks.
module tb_bus_slave_ram;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   bus::m2s_s m2s [3];
   bus::s2m_s s2m [3];

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   bit   drain = 1'b0;
   bit   exp_stall [3];
   exp_t q [3][$];
   logic [31:0] rmem [3][1024];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bus_slave_ram #(
         .WAIT_CYCLES(g == 0 ? 0 : g + 2)
      ) u_dut (
         .clk  (clk),
         .rst  (rst),
         .bus_i(m2s[g]),
         .bus_o(s2m[g])
      );
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         for (int g = 0; g < 3; g++) begin
            checks++;
            if (s2m[g].stall !== exp_stall[g]) begin
               errors++;
               $display("FAIL stall inst=%0d cyc=%0d got=%b want=%b",
                        g, cyc, s2m[g].stall, exp_stall[g]);
            end
            checks++;
            if (s2m[g].valid === 1'b1) begin
               if (q[g].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid inst=%0d cyc=%0d", g, cyc);
               end else begin
                  e = q[g].pop_front();
                  if (cyc != e.cyc || s2m[g].err !== e.err ||
                      s2m[g].data !== e.data) begin
                     errors++;
                     $display("FAIL resp inst=%0d got cyc=%0d err=%b data=%h want cyc=%0d err=%b data=%h",
                              g, cyc, s2m[g].err, s2m[g].data,
                              e.cyc, e.err, e.data);
                  end
               end
            end else if (s2m[g].valid !== 1'b0 || s2m[g].err !== 1'b0 ||
                         s2m[g].data !== 32'd0) begin
               errors++;
               $display("FAIL idle_out inst=%0d cyc=%0d got v=%b e=%b d=%h want 0",
                        g, cyc, s2m[g].valid, s2m[g].err, s2m[g].data);
            end
            if (drain) begin
               checks++;
               if (q[g].size() != 0) begin
                  errors++;
                  $display("FAIL missing_resp inst=%0d got=%0d pending want=0",
                           g, q[g].size());
               end
            end
         end
      end
   end

   function automatic int nw(input int g);
      return (g == 0) ? 0 : g + 2;
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int g, input logic we, input logic [29:0] addr,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic u);
      int   n;
      int   o;
      exp_t e;
      n = nw(g);
      o = int'(addr % 1024);
      e.cyc  = cyc + n + 1;
      e.err  = (addr >= 30'd1024);
`ifdef BUS_SLAVE_KPROT_EN
      if (u && o < 256) e.err = 1'b1;
`endif
      e.data = 32'd0;
      if (!e.err) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (m[b]) rmem[g][o][8*b +: 8] = d[8*b +: 8];
         end else begin
            e.data = rmem[g][o];
         end
      end
      q[g].push_back(e);
      m2s[g] = '{req: 1'b1, we: we, addr: addr, data: d,
                 byte_mask: m, user_mode: u};
      exp_stall[g] = (n > 0);
      next_cyc();
      m2s[g] = '{req: 1'b0, we: 1'($urandom), addr: 30'($urandom),
                 data: $urandom, byte_mask: 4'($urandom),
                 user_mode: 1'($urandom)};
      for (int k = 1; k <= n; k++) begin
         exp_stall[g] = (k < n);
         next_cyc();
      end
      exp_stall[g] = 1'b0;
   endtask

   task automatic wr(input int g, input int o, input logic [31:0] d);
      issue(g, 1'b1, 30'(o), d, 4'hF, 1'b0);
   endtask

   task automatic rd(input int g, input int o);
      issue(g, 1'b0, 30'(o), $urandom, 4'($urandom), 1'b0);
   endtask

   initial begin
      int o;
      logic [29:0] a;
      for (int g = 0; g < 3; g++) begin
         m2s[g] = '0;
         exp_stall[g] = 1'b0;
      end
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (3) next_cyc();
      rst = 1'b0;

      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 32; i++) wr(g, i, $urandom);
         wr(g, 256, $urandom);
      end

      wr(0, 16, 32'hDEADBEEF);
      rd(0, 16);
      wr(1, 3, 32'h12345678);
      rd(1, 3);
      rd(1, 3);
      wr(1, 4, 32'h11223344);
      issue(1, 1'b1, 30'd4, 32'hAABBCCDD, 4'b0101, 1'b0);
      rd(1, 4);
      issue(1, 1'b1, 30'd5, 32'hCAFEF00D, 4'h0, 1'b0);
      rd(1, 5);
      for (int g = 0; g < 2; g++) begin
         issue(g, 1'b1, 30'd1028, 32'h55AA55AA, 4'hF, 1'b0);
         rd(g, 4);
         issue(g, 1'b0, 30'd1028, 32'h0, 4'hF, 1'b0);
         issue(g, 1'b0, 30'h3FFFFFFF, 32'h0, 4'hF, 1'b0);
      end
`ifdef BUS_SLAVE_KPROT_EN
      issue(0, 1'b1, 30'd5, 32'h0BAD0BAD, 4'hF, 1'b1);
      rd(0, 5);
      wr(0, 5, 32'h600D600D);
      rd(0, 5);
      issue(0, 1'b0, 30'd256, 32'h0, 4'hF, 1'b1);
      issue(1, 1'b0, 30'd256, 32'h0, 4'hF, 1'b1);
`endif

      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 150; i++) begin
            o = $urandom_range(0, 31);
            a = 30'(o);
            if ($urandom_range(0, 9) == 0)
               a = 30'($urandom_range(1024, 32'h3FFFFFFF));
            issue(g, 1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
         end
      end

      m2s[2] = '{req: 1'b1, we: 1'b1, addr: 30'd7, data: ~rmem[2][7],
                 byte_mask: 4'hF, user_mode: 1'b0};
      exp_stall[2] = 1'b1;
      next_cyc();
      m2s[2] = '0;
      next_cyc();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      exp_stall[2] = 1'b0;
      repeat (8) next_cyc();
      rd(2, 7);
      wr(2, 9, 32'h0F1E2D3C);
      rd(2, 9);

      repeat (10) next_cyc();
      drain = 1'b1;
      next_cyc();
      drain = 1'b0;
      mon_en = 1'b0;
      next_cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
